// File: rtl/latch_sampler_pkg.sv
// rtl/latch_sampler_pkg.sv - shared FSM state type and stability-counter width for latch_sampler
package latch_sampler_pkg;

  // Width of the debounce stability counter (also caps STABLE_CYCLES at 255)
  localparam int STAB_CNT_W = 8;

  // Debounce FSM: two settled levels and two "checking" states between them
  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } ls_state_t;

endpackage

// File: rtl/latch_sampler_sync.sv
// rtl/latch_sampler_sync.sv - SYNC_STAGES-deep flop chain bringing an async latch output into clk
module latch_sampler_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the chain; only the last flop is used downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/latch_sampler.sv
// rtl/latch_sampler.sv - debounced latch sampler with edge counter; LATCH_SAMPLER_MISMATCH_EN adds q/qb check
module latch_sampler
  import latch_sampler_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             q_in,
  input  logic             qb_in,
  input  logic             sample_en,
  input  logic             clr_cnt,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_ovf,
  output logic             mismatch
);

  // Counter value at which the next agreeing sample accepts the new level
  localparam logic [STAB_CNT_W-1:0] STAB_LAST = STAB_CNT_W'(STABLE_CYCLES - 1);

  logic                  s;
  ls_state_t             state;
  ls_state_t             state_nxt;
  logic [STAB_CNT_W-1:0] stab_cnt;
  logic [STAB_CNT_W-1:0] stab_cnt_nxt;
  logic                  level_nxt;
  logic                  rise_nxt;
  logic                  fall_nxt;

  latch_sampler_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_q (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (q_in),
    .q       (s)
  );

  // FSM state register plus its registered outputs, all cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LOW;
      stab_cnt   <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      stab_cnt   <= stab_cnt_nxt;
      level_out  <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // Next state: a level change is accepted only after STABLE_CYCLES agreeing samples;
  // with sample_en low everything holds
  always_comb begin
    state_nxt    = state;
    stab_cnt_nxt = stab_cnt;
    if (sample_en) begin
      unique case (state)
        LOW: begin
          if (s) begin
            state_nxt    = CHK_HI;
            stab_cnt_nxt = STAB_CNT_W'(1);
          end
        end
        CHK_HI: begin
          if (!s) begin
            state_nxt    = LOW;
            stab_cnt_nxt = '0;
          end else if (stab_cnt == STAB_LAST) begin
            state_nxt    = HIGH;
            stab_cnt_nxt = '0;
          end else begin
            stab_cnt_nxt = stab_cnt + STAB_CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            state_nxt    = CHK_LO;
            stab_cnt_nxt = STAB_CNT_W'(1);
          end
        end
        CHK_LO: begin
          if (s) begin
            state_nxt    = HIGH;
            stab_cnt_nxt = '0;
          end else if (stab_cnt == STAB_LAST) begin
            state_nxt    = LOW;
            stab_cnt_nxt = '0;
          end else begin
            stab_cnt_nxt = stab_cnt + STAB_CNT_W'(1);
          end
        end
        default: begin
          state_nxt    = LOW;
          stab_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Outputs: pulses only on accepted transitions (CHK->settled of the new level),
  // never on an aborted check, so rise and fall are mutually exclusive
  always_comb begin
    rise_nxt  = (state == CHK_HI) && (state_nxt == HIGH);
    fall_nxt  = (state == CHK_LO) && (state_nxt == LOW);
    level_nxt = (state_nxt == HIGH) || (state_nxt == CHK_LO);
  end

  // Saturating count of accepted rising edges; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (clr_cnt) begin
      edge_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (rise_pulse) begin
      if (&edge_cnt) begin
        cnt_ovf <= 1'b1;
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

`ifdef LATCH_SAMPLER_MISMATCH_EN
  logic                  sb;
  logic [STAB_CNT_W-1:0] eq_cnt;

  latch_sampler_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_qb (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (qb_in),
    .q       (sb)
  );

  // Sticky flag once q and qb agree for STABLE_CYCLES consecutive samples;
  // eq_cnt counts prior agreeing cycles and saturates at STAB_LAST
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eq_cnt   <= '0;
      mismatch <= 1'b0;
    end else begin
      if (s != sb) begin
        eq_cnt <= '0;
      end else if (eq_cnt != STAB_LAST) begin
        eq_cnt <= eq_cnt + STAB_CNT_W'(1);
      end
      if (clr_cnt) begin
        mismatch <= 1'b0;
      end else if ((s == sb) && (eq_cnt == STAB_LAST)) begin
        mismatch <= 1'b1;
      end
    end
  end
`else
  logic unused_qb;
  assign unused_qb = qb_in;
  assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_latch_sampler.sv
// tb/tb_latch_sampler.sv - self-checking bench for latch_sampler (vector table plus pulse scoreboard)
module tb_latch_sampler;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 8;
  localparam int LAT           = SYNC_STAGES + STABLE_CYCLES - 1;
`ifdef LATCH_SAMPLER_MISMATCH_EN
  localparam logic MM_EXP = 1'b1;
`else
  localparam logic MM_EXP = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic             q_in      = 1'b0;
  logic             qb_in     = 1'b1;
  logic             sample_en = 1'b1;
  logic             clr_cnt   = 1'b0;
  logic             level_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] edge_cnt;
  logic             cnt_ovf;
  logic             mismatch;

  int cyc       = 0;
  int checks    = 0;
  int errors    = 0;
  int exp_edges = 0;

  typedef struct {
    bit rise;
    int at;
  } ev_t;
  ev_t sb_q[$];

  typedef struct {
    int hi;
    int lo;
    bit exp_rise;
    bit exp_fall;
  } vec_t;
  vec_t vecs[8];

  latch_sampler #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .q_in      (q_in),
    .qb_in     (qb_in),
    .sample_en (sample_en),
    .clr_cnt   (clr_cnt),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .edge_cnt  (edge_cnt),
    .cnt_ovf   (cnt_ovf),
    .mismatch  (mismatch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hold q at lvl for n clock edges; if a level change must be accepted, queue its pulse
  task automatic seg(input bit lvl, input int n, input bit exp_ev);
    ev_t e;
    q_in  = lvl;
    qb_in = ~lvl;
    if (exp_ev) begin
      e.rise = lvl;
      e.at   = cyc + 1 + LAT;
      sb_q.push_back(e);
      if (lvl) exp_edges++;
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_rise_at(input int at);
    ev_t e;
    e.rise = 1'b1;
    e.at   = at;
    sb_q.push_back(e);
    exp_edges++;
  endtask

  initial begin
    ev_t e;
    int  k;

    vecs[0] = '{hi: 8, lo: 8,  exp_rise: 1'b1, exp_fall: 1'b1};
    vecs[1] = '{hi: 3, lo: 6,  exp_rise: 1'b0, exp_fall: 1'b0};
    vecs[2] = '{hi: 4, lo: 4,  exp_rise: 1'b1, exp_fall: 1'b1};
    vecs[3] = '{hi: 1, lo: 2,  exp_rise: 1'b0, exp_fall: 1'b0};
    vecs[4] = '{hi: 5, lo: 3,  exp_rise: 1'b1, exp_fall: 1'b0};
    vecs[5] = '{hi: 2, lo: 6,  exp_rise: 1'b0, exp_fall: 1'b1};
    vecs[6] = '{hi: 6, lo: 2,  exp_rise: 1'b1, exp_fall: 1'b0};
    vecs[7] = '{hi: 3, lo: 10, exp_rise: 1'b0, exp_fall: 1'b1};

    fork
      forever begin
        @(negedge clk);
        if (rise_pulse || fall_pulse) begin
          check("pulse_exclusive", 32'(rise_pulse & fall_pulse), 0);
          check("scoreboard_has_event", 32'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("pulse_kind_rise", 32'(rise_pulse), 32'(e.rise));
            check("pulse_cycle", cyc, e.at);
            check("level_after_pulse", 32'(level_out), 32'(e.rise));
          end
        end
      end
    join_none

    // Reset state, observed after a clock edge with reset still held
    @(negedge clk);
    check("rst_level_out", 32'(level_out), 0);
    check("rst_rise_pulse", 32'(rise_pulse), 0);
    check("rst_fall_pulse", 32'(fall_pulse), 0);
    check("rst_edge_cnt", 32'(edge_cnt), 0);
    check("rst_cnt_ovf", 32'(cnt_ovf), 0);
    check("rst_mismatch", 32'(mismatch), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic accepted rise: pulse at edge SYNC+STABLE-1, count becomes 1
    seg(1'b1, 8, 1'b1);
    check("first_edge_cnt", 32'(edge_cnt), 1);
    check("first_level_high", 32'(level_out), 1);
    seg(1'b0, 8, 1'b1);

    // Too-short high: rejected
    seg(1'b1, 3, 1'b0);
    seg(1'b0, 6, 1'b0);
    check("short_level_low", 32'(level_out), 0);
    check("short_edge_cnt", 32'(edge_cnt), 32'(exp_edges));

    // Vector table
    for (int i = 0; i < 8; i++) begin
      seg(1'b1, vecs[i].hi, vecs[i].exp_rise);
      seg(1'b0, vecs[i].lo, vecs[i].exp_fall);
      check("vec_edge_cnt", 32'(edge_cnt), 32'(exp_edges));
    end

    // Freeze in CHK_HI with counter=2, then resume: rise two cycles after re-enable
    q_in  = 1'b1;
    qb_in = 1'b0;
    repeat (4) @(negedge clk);
    sample_en = 1'b0;
    repeat (10) @(negedge clk);
    check("frozen_level_low", 32'(level_out), 0);
    sample_en = 1'b1;
    expect_rise_at(cyc + 2);
    repeat (6) @(negedge clk);
    check("resume_edge_cnt", 32'(edge_cnt), 32'(exp_edges));
    seg(1'b0, 10, 1'b1);

    // Async reset mid-cycle while HIGH: immediate drop, no fall pulse afterwards
    seg(1'b1, 8, 1'b1);
    check("pre_rst_level_high", 32'(level_out), 1);
    #2;
    reset_n = 1'b0;
    q_in    = 1'b0;
    qb_in   = 1'b1;
    #1;
    check("async_rst_level", 32'(level_out), 0);
    check("async_rst_edge_cnt", 32'(edge_cnt), 0);
    exp_edges = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_level", 32'(level_out), 0);

    // Reset during CHK_HI abandons the check
    q_in  = 1'b1;
    qb_in = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    q_in    = 1'b0;
    qb_in   = 1'b1;
    #1;
    check("chk_rst_level", 32'(level_out), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("chk_rst_edge_cnt", 32'(edge_cnt), 0);

    // Saturation: 255 edges fill the counter, the 256th sets overflow
    for (int i = 0; i < 256; i++) begin
      seg(1'b1, 4, 1'b1);
      seg(1'b0, 4, 1'b1);
      if (i == 254) begin
        check("cnt_255_value", 32'(edge_cnt), 255);
        check("cnt_255_no_ovf", 32'(cnt_ovf), 0);
      end
    end
    check("sat_edge_cnt", 32'(edge_cnt), 255);
    check("sat_cnt_ovf", 32'(cnt_ovf), 1);

    // Clear in the same cycle as a rise pulse: clear wins
    q_in  = 1'b1;
    qb_in = 1'b0;
    expect_rise_at(cyc + 1 + LAT);
    k = 0;
    while (!rise_pulse && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("clr_rise_seen", 32'(rise_pulse), 1);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_edge_cnt", 32'(edge_cnt), 0);
    check("clr_cnt_ovf", 32'(cnt_ovf), 0);
    exp_edges = 0;
    repeat (2) @(negedge clk);
    seg(1'b0, 10, 1'b1);

    // q and qb equal: sticky mismatch (only with the option built in), cleared by clr_cnt
    q_in  = 1'b1;
    qb_in = 1'b1;
    expect_rise_at(cyc + 1 + LAT);
    repeat (8) @(negedge clk);
    check("mismatch_set", 32'(mismatch), 32'(MM_EXP));
    qb_in = 1'b0;
    repeat (6) @(negedge clk);
    check("mismatch_sticky", 32'(mismatch), 32'(MM_EXP));
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("mismatch_cleared", 32'(mismatch), 0);
    check("mismatch_clr_edge_cnt", 32'(edge_cnt), 0);
    seg(1'b0, 10, 1'b1);
    check("mismatch_stays_clear", 32'(mismatch), 0);

    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
